// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default parameter values for param_register_file.
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_CLEAR_VAL = 0;

endpackage

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sweep sequencer; walks every address once, then raises ready.
`default_nettype none

module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                r_ready;
  logic                w_clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= (w_state_nxt == READY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clr_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we  = 1'b1;
        w_ptr_nxt = r_ptr + 1'b1;
        // Last entry is cleared on this edge; ready rises together with it.
        if (&r_ptr) w_state_nxt = READY;
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Reset must block the sweep write so a reset edge never touches the array.
  assign o_clr_we   = w_clr_we & ~rst;
  assign o_clr_addr = r_ptr;
  assign o_ready    = r_ready;

endmodule

`default_nettype wire

// File: rtl/param_register_file.sv
// param_register_file: WIDTH x 2**ADDR_W register file, 2 async reads, 1 sync write, post-reset clear.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding to the read ports.
`default_nettype none

module param_register_file
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               ADDR_W    = DEF_ADDR_W,
  parameter logic [WIDTH-1:0] CLEAR_VAL = WIDTH'(DEF_CLEAR_VAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] sel_in,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] sel_o1,
  input  logic [ADDR_W-1:0] sel_o2,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ready;
  logic [WIDTH-1:0]  w_o1;
  logic [WIDTH-1:0]  w_o2;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= CLEAR_VAL;
    end else if (!rst && w_ready && we) begin
      r_mem[sel_in] <= in;
    end
  end

  always_comb begin
    w_o1 = r_mem[sel_o1];
    w_o2 = r_mem[sel_o2];
`ifdef REGFILE_BYPASS_EN
    if (w_ready && we && (sel_o1 == sel_in)) w_o1 = in;
    if (w_ready && we && (sel_o2 == sel_in)) w_o2 = in;
`endif
    // Uncleared entries must never leak out while the sweep is running.
    if (!w_ready) begin
      w_o1 = CLEAR_VAL;
      w_o2 = CLEAR_VAL;
    end
  end

  assign o1    = w_o1;
  assign o2    = w_o2;
  assign ready = w_ready;

endmodule

`default_nettype wire

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the 16x8 register file: configurable width and depth, write enable, and a synchronous clear after reset.
- A sequencer sweeps every entry to a known value after reset. `ready` reports when the sweep is done.
- Two asynchronous read ports and one synchronous write port. Sits between the decoder and the ALU in the datapath.

Parameters:
- WIDTH, 8, data bits per register
- ADDR_W, 4, address bits; DEPTH = 2**ADDR_W entries (derived, not overridable)
- CLEAR_VAL, 0, WIDTH-bit value written to every entry by the clear sweep

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable; sampled only when ready=1
- sel_in  in  ADDR_W  write address
- in  in  WIDTH  write data
- sel_o1  in  ADDR_W  read address, port 1
- sel_o2  in  ADDR_W  read address, port 2
- o1  out  WIDTH  read data, port 1 (combinational)
- o2  out  WIDTH  read data, port 2 (combinational)
- ready  out  1  high once the clear sweep completes; low during reset and sweep

Behaviour:
- State machine:
  - Two states: CLEAR, READY.
  - rst=1 at a posedge: state<=CLEAR, ptr<=0, no array write. This holds for any state, so reset mid-sweep restarts the sweep at 0 and reset in READY discards contents.
- CLEAR with rst=0:
  - Each posedge writes mem[ptr]<=CLEAR_VAL and increments ptr.
  - On the edge that writes ptr==DEPTH-1, state<=READY; ptr wraps to 0, don't-care.
  - The sweep therefore takes exactly DEPTH edges after the first edge with rst=0.
- ready:
  - Registered: ready = (state==READY).
  - Reset value 0. It rises on the same edge that clears the last entry.
- Writes:
  - In READY, we=1 at a posedge gives mem[sel_in]<=in.
  - we=0 leaves the array unchanged.
  - we is ignored entirely in CLEAR and while rst=1.
- Reads:
  - o1=mem[sel_o1], o2=mem[sel_o2], combinational with zero latency.
  - In CLEAR, both outputs are forced to CLEAR_VAL so uncleared entries are never visible.
  - The outputs are not registered; no reset value is needed beyond this masking.
- Same-address read and write in one cycle: reads return the pre-edge value, unless the optional feature is enabled.
- Both read ports may address the same entry; each returns identical data.
- Widths: all addresses are full ADDR_W with no out-of-range case. Data is not extended or truncated.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: while ready=1, if we=1 and sel_oN==sel_in, then oN=in in that same cycle (write-through forwarding). Each port is forwarded independently.
- Not defined: reads always show stored contents; new data is visible the cycle after the write edge.
- CLEAR masking takes priority over bypass in both builds.

Decomposition:
- Package regfile_pkg holds:
  - the state typedef (enum CLEAR/READY)
  - default constants DEF_WIDTH=8, DEF_ADDR_W=4, DEF_CLEAR_VAL=0
- Sub-module regfile_clear_seq (parameter ADDR_W) is natural:
  - holds the state, ptr and ready
  - outputs clr_we and clr_addr to the array mux
- The top level holds the storage array, write mux, read mux and bypass.

Test Plan:
- Reset sweep: rst=1 for 2 edges, then rst=0 -> ready=0 for 15 edges, 1 after edge 16. Every read of 0..15 then returns 0x00.
- Basic write/read, after ready: we=1, sel_in=3, in=0xA5 -> o1 with sel_o1=3 reads 0xA5 the next cycle; o2 on address 4 still reads 0x00.
- Write gating: we=0, sel_in=3, in=0xFF -> address 3 stays 0xA5. Writes during CLEAR have no effect: after ready, the targeted entry reads 0x00.
- Mid-sweep reset: rst=1 at sweep edge 7, then release -> ready rises exactly 16 edges after release. o1/o2 read 0x00 throughout the sweep.
- Same-address access: we=1, sel_in=5, in=0x3C, sel_o1=sel_o2=5 in the same cycle:
  - without REGFILE_BYPASS_EN -> both outputs 0x00 that cycle, 0x3C the next;
  - with it -> both read 0x3C immediately.
- Reset in READY: fill all entries with 0x5A, pulse rst -> ready drops, sweep reruns, all entries read 0x00 after 16 edges.
